bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").

---
 rtl/bin2bcd_pkg.sv | 29 ++
 rtl/bin2bcd_seq_digit_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 99 +++++++++
 tb/tb_bin2bcd_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width able to hold the value bin_w (the initial shift count).
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // Smallest digit count whose decimal range covers 2**bin_w - 1.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_val;
        longint unsigned limit;
        int              d;
        max_val = (64'd1 << bin_w) - 64'd1;
        limit   = 64'd10;
        d       = 1;
        while (limit <= max_val) begin
            d     = d + 1;
            limit = limit * 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Single BCD digit pre-shift correction: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit shifted into the BCD
// scratch per clock, result published on a single-cycle done pulse.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int BCD_W = 4 * DIGITS;

    generate
        if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
            $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   adj;
    logic               adj_msb_unused;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[4*gi +: 4]),
            .digit_o (adj[4*gi +: 4])
        );
    end

    // With enough digits the top scratch bit never carries a 1 out on shift.
    assign adj_msb_unused = adj[BCD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                // Only the completed value ever reaches the output register.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scratch_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int n);
        logic [11:0] r;
        int v;
        r = '0;
        v = n;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [11:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic convert(input logic [7:0] b, input bit scramble,
                           output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (scramble) bin = 8'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic conv_check(input string tag, input logic [7:0] b, input bit scramble,
                              input bit full);
        int lat, bc;
        convert(b, scramble, lat, bc);
        check_eq({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(int'(b))));
        check_eq({tag, " digits<=9"}, 32'(digits_ok(bcd)), 32'd1);
        if (full) begin
            check_eq({tag, " latency"}, 32'(lat), 32'd8);
            check_eq({tag, " busy cycles"}, 32'(bc), 32'd8);
            @(posedge clk);
            #1;
            check_eq({tag, " done width"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, dcount, dcyc, d1, d2;
        logic [11:0] got, r1, r2;
        logic [4:0]  s;
        logic [3:0]  sum;
        logic        cout;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        #12;
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        conv_check("bin0", 8'd0, 1'b0, 1'b1);
        conv_check("bin255", 8'd255, 1'b1, 1'b1);
        check_eq("bin255 literal", 32'(bcd), 32'h255);

        // 99 then downstream BCD add of its two low digits: 9 + 9 = 18.
        conv_check("bin99", 8'd99, 1'b0, 1'b1);
        s    = 5'(bcd[3:0]) + 5'(bcd[7:4]);
        cout = (s > 5'd9);
        sum  = cout ? 4'(s + 5'd6) : s[3:0];
        check_eq("adder sum", 32'(sum), 32'h8);
        check_eq("adder cout", 32'(cout), 32'd1);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd37;
        @(posedge clk);
        #1;
        start  = 1'b0;
        dcount = 0;
        dcyc   = -1;
        got    = '0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                start = 1'b1;
                bin   = 8'd200;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                dcount++;
                got  = bcd;
                dcyc = i;
            end
        end
        check_eq("ignore result", 32'(got), 32'h037);
        check_eq("ignore pulses", 32'(dcount), 32'd1);
        check_eq("ignore latency", 32'(dcyc), 32'd8);

        // asynchronous reset mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd128;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst done", 32'(done), 32'd0);
        check_eq("midrst bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check_eq("midrst no done", 32'(dcount), 32'd0);
        conv_check("after rst 64", 8'd64, 1'b0, 1'b1);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd10;
        d1 = -1;
        d2 = -1;
        r1 = '0;
        r2 = '0;
        for (int i = 0; i < 40 && d2 < 0; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 < 0) begin
                    d1  = i;
                    r1  = bcd;
                    bin = 8'd250;
                end else begin
                    d2 = i;
                    r2 = bcd;
                end
            end
            if (d1 >= 0 && i == d1 + 1) start = 1'b0;
        end
        start = 1'b0;
        check_eq("b2b first", 32'(r1), 32'h010);
        check_eq("b2b second", 32'(r2), 32'h250);
        check_eq("b2b spacing", 32'(d2 - d1), 32'd9);

        // randomized operands, gaps and bin churn during conversion
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            conv_check($sformatf("rand%0d", t), 8'($urandom), 1'b1, 1'b1);
        end

        // exhaustive sweep
        for (int v = 0; v < 256; v++)
            conv_check($sformatf("sweep%0d", v), 8'(v), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
